card_swipe_decoder: RTL

//  Upstream stage of electronic_card_lock. Deserialises one card swipe
//  (sentinel, type, 16-bit entry code, parity) from the reader's strobe/data

---
 rtl/card_swipe_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/card_swipe_decoder.sv
// Card reader front end: synchronises the reader lines, deserialises a 23-bit
// swipe frame and holds a checked entry code and card type until the card is pulled.
module card_swipe_decoder #(
    parameter int         TIMEOUT_CYCLES = 27000,
    parameter logic [3:0] SENTINEL       = 4'b1011
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        card_present,
    input  logic        card_strobe,
    input  logic        card_data,
    output logic        card_read,
    output logic [15:0] entry_code_on_card,
    output logic [1:0]  card_type,
    output logic        frame_error
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);
    localparam logic [4:0] LAST_BIT = 5'd22;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT    = 3'd1,
        CHECK    = 3'd2,
        HOLD     = 3'd3,
        WAIT_OUT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        present_sync_q, strobe_sync_q, data_sync_q;
    logic              strobe_prev_q;
    logic [22:0]       shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              card_read_q, card_read_d;
    logic [15:0]       code_q, code_d;
    logic [1:0]        type_q, type_d;
    logic              frame_error_q, frame_error_d;

    logic present_s, data_s, strobe_rise;
    logic sentinel_ok, parity_ok;

    assign present_s   = present_sync_q[1];
    assign data_s      = data_sync_q[1];
    assign strobe_rise = strobe_sync_q[1] & ~strobe_prev_q;
    assign sentinel_ok = (shift_q[22:19] == SENTINEL);
    // Odd parity across type, code and the parity bit itself
    assign parity_ok   = ^shift_q[18:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            present_sync_q <= '0;
            strobe_sync_q  <= '0;
            data_sync_q    <= '0;
            strobe_prev_q  <= 1'b0;
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            card_read_q    <= 1'b0;
            code_q         <= '0;
            type_q         <= '0;
            frame_error_q  <= 1'b0;
        end else begin
            present_sync_q <= {present_sync_q[0], card_present};
            strobe_sync_q  <= {strobe_sync_q[0], card_strobe};
            data_sync_q    <= {data_sync_q[0], card_data};
            strobe_prev_q  <= strobe_sync_q[1];
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            card_read_q    <= card_read_d;
            code_q         <= code_d;
            type_q         <= type_d;
            frame_error_q  <= frame_error_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        card_read_d   = card_read_q;
        code_d        = code_q;
        type_d        = type_q;
        frame_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (present_s && strobe_rise) begin
                    shift_d   = {22'd0, data_s};
                    bit_cnt_d = 5'd1;
                    gap_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                // Removal beats timeout, and timeout beats a coincident strobe edge
                if (!present_s) begin
                    state_d   = IDLE;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end else if (gap_cnt_q == GAP_LIMIT) begin
                    frame_error_d = 1'b1;
                    state_d       = WAIT_OUT;
                    shift_d       = '0;
                    bit_cnt_d     = '0;
                    gap_cnt_d     = '0;
                end else if (strobe_rise) begin
                    shift_d   = {shift_q[21:0], data_s};
                    gap_cnt_d = '0;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end else if (gap_cnt_q != GAP_LIMIT) begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                shift_d = '0;
                if (sentinel_ok && parity_ok) begin
                    card_read_d = 1'b1;
                    code_d      = shift_q[16:1];
                    type_d      = shift_q[18:17];
                    state_d     = HOLD;
                end else begin
                    frame_error_d = 1'b1;
                    state_d       = WAIT_OUT;
                end
            end
            HOLD: begin
                if (!present_s) begin
                    card_read_d = 1'b0;
                    code_d      = '0;
                    type_d      = '0;
                    state_d     = IDLE;
                end
            end
            WAIT_OUT: begin
                if (!present_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign card_read          = card_read_q;
    assign entry_code_on_card = code_q;
    assign card_type          = type_q;
    assign frame_error        = frame_error_q;

endmodule
